// File: rtl/sodor5_dmem_pkg.sv
// Shared constants and lane helpers for the sodor5 data-memory controller.
package sodor5_dmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic FCN_LD = 1'b0;
  localparam logic FCN_ST = 1'b1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Misalignment or a funct3 that is not legal for the given direction.
  function automatic logic access_err(input logic fcn, input logic [2:0] f3, input logic [1:0] off);
    logic err;
    case (f3)
      F3_B:    err = 1'b0;
      F3_H:    err = off[0];
      F3_W:    err = (off != 2'b00);
      F3_BU:   err = (fcn == FCN_ST);
      F3_HU:   err = (fcn == FCN_ST) || off[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << {off[1], 1'b0};
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {off, 3'b000};
    case (f3)
      F3_B:    r = {{24{s[7]}}, s[7:0]};
      F3_H:    r = {{16{s[15]}}, s[15:0]};
      F3_BU:   r = {24'd0, s[7:0]};
      F3_HU:   r = {16'd0, s[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word, input logic [31:0] new_word,
                                              input logic [3:0] mask);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sodor5_dmem_lbuf.sv
// Single-entry load buffer: hit compare on lookup, fill on load, byte-merge on store.
module sodor5_dmem_lbuf
  import sodor5_dmem_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             hit,
  output logic [31:0]      hit_data,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [31:0]      fill_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_mask,
  input  logic [31:0]      wr_data
);

  logic             entry_vld;
  logic [IDX_W-1:0] entry_idx;
  logic [31:0]      entry_dat;

  assign hit      = entry_vld && (entry_idx == lookup_idx);
  assign hit_data = entry_dat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_vld <= 1'b0;
      entry_idx <= '0;
      entry_dat <= '0;
    end else if (fill_en) begin
      entry_vld <= 1'b1;
      entry_idx <= fill_idx;
      entry_dat <= fill_data;
    end else if (wr_en && entry_vld && (wr_idx == entry_idx)) begin
      entry_dat <= merge_bytes(entry_dat, wr_data, wr_mask);
    end
  end

endmodule

// File: rtl/sodor5_dmem_ctrl.sv
// Multi-cycle data-memory controller behind the sodor5 MEM stage; each access takes LATENCY cycles.
// Defining SODOR5_DMEM_LBUF_EN adds a single-entry load buffer that answers repeat loads in one cycle.
module sodor5_dmem_ctrl
  import sodor5_dmem_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int LATENCY    = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_fcn,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_data,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err,
  output logic            busy
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam int         AW       = DEPTH_LOG2 + 2;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit         DIRECT   = (LATENCY == 1);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  r_fcn;
  logic [2:0]            r_f3;
  logic [AW-1:0]         r_addr;
  logic [31:0]           r_data;
  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic                  hit;
  logic [31:0]           hit_data;
  logic                  go_resp;
  logic                  a_fcn;
  logic [2:0]            a_f3;
  logic [AW-1:0]         a_addr;
  logic [31:0]           a_data;
  logic [DEPTH_LOG2-1:0] a_idx;
  logic                  a_err;
  logic [3:0]            a_mask;
  logic [31:0]           a_word;
  logic [31:0]           st_word;
  logic                  unused_addr;

  assign unused_addr = ^req_addr[XLEN-1:AW];

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);
  assign accept     = (state == ST_IDLE) && req_valid;

  // Direct IDLE->RESP paths perform the access with the live request, others use the latched copy.
  always_comb begin
    a_fcn  = r_fcn;
    a_f3   = r_f3;
    a_addr = r_addr;
    a_data = r_data;
    if (state == ST_IDLE) begin
      a_fcn  = req_fcn;
      a_f3   = req_funct3;
      a_addr = req_addr[AW-1:0];
      a_data = req_data[31:0];
    end
  end

  assign a_idx   = a_addr[AW-1:2];
  assign a_err   = access_err(a_fcn, a_f3, a_addr[1:0]);
  assign a_mask  = lane_mask(a_f3, a_addr[1:0]);
  assign st_word = a_data << {a_addr[1:0], 3'b000};
  assign a_word  = (accept && hit) ? hit_data : mem[a_idx];
  assign go_resp = (accept && (DIRECT || hit)) || ((state == ST_BUSY) && (cnt == 4'd0));

`ifdef SODOR5_DMEM_LBUF_EN
  logic lb_hit;

  sodor5_dmem_lbuf #(.IDX_W(DEPTH_LOG2)) u_lbuf (
    .clk        (clk),
    .reset_n    (reset_n),
    .lookup_idx (a_idx),
    .hit        (lb_hit),
    .hit_data   (hit_data),
    .fill_en    (go_resp && (a_fcn == FCN_LD) && !a_err),
    .fill_idx   (a_idx),
    .fill_data  (a_word),
    .wr_en      (go_resp && (a_fcn == FCN_ST) && !a_err),
    .wr_idx     (a_idx),
    .wr_mask    (a_mask),
    .wr_data    (st_word)
  );

  assign hit = lb_hit && (a_fcn == FCN_LD) && !a_err;
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      r_fcn  <= FCN_LD;
      r_f3   <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            r_fcn  <= req_fcn;
            r_f3   <= req_funct3;
            r_addr <= req_addr[AW-1:0];
            r_data <= req_data[31:0];
            if (DIRECT || hit) begin
              state <= ST_RESP;
            end else begin
              cnt   <= CNT_INIT;
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory and response registers update together on the edge that enters RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_data <= '0;
      resp_err  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (go_resp) begin
      resp_err  <= a_err;
      resp_data <= (a_err || (a_fcn == FCN_ST)) ? '0 : XLEN'(load_extend(a_f3, a_addr[1:0], a_word));
      if (!a_err && (a_fcn == FCN_ST)) begin
        mem[a_idx] <= merge_bytes(mem[a_idx], st_word, a_mask);
      end
    end else if (state == ST_RESP) begin
      resp_data <= '0;
      resp_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sodor5_dmem_ctrl.sv
// Scoreboard bench for sodor5_dmem_ctrl: expected responses queued at accept, checked on resp_valid.
module tb_sodor5_dmem_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_fcn = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_data = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sodor5_dmem_ctrl #(.XLEN(32), .DEPTH_LOG2(4), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_fcn    (req_fcn),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Cycles from the accepting edge to the edge that first samples resp_valid high.
  function automatic int lat_for(input bit buffered);
`ifdef SODOR5_DMEM_LBUF_EN
    return buffered ? 1 : LAT;
`else
    return buffered ? LAT : LAT;
`endif
  endfunction

  task automatic access(input string name, input logic fcn, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    exp_t e;
    int   n;
    @(negedge clk);
    check_val({name, ".ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_fcn    = fcn;
    req_funct3 = f3;
    req_addr   = addr;
    req_data   = data;
    e.data = exp_data;
    e.err  = exp_err;
    e.lat  = exp_lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = ~addr;
    req_data   = 32'hFFFF_FFFF;
    req_funct3 = ~f3;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val({name, ".seen"}, 32'(resp_valid), 32'd1);
    e = sb.pop_front();
    check_val({name, ".data"}, resp_data, e.data);
    check_val({name, ".err"}, 32'(resp_err), 32'(e.err));
    check_val({name, ".lat"}, 32'(n + 1), 32'(e.lat));
    @(posedge clk);
    #1;
    check_val({name, ".pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.ready", 32'(req_ready), 32'd1);
    check_val("rst.resp_valid", 32'(resp_valid), 32'd0);
    check_val("rst.resp_data", resp_data, 32'd0);
    check_val("rst.resp_err", 32'(resp_err), 32'd0);
    check_val("rst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    access("sw8",   1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, LAT);
    access("lw8",   1'b0, 3'b010, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, LAT);

    access("sw0",   1'b1, 3'b010, 32'h0, 32'h0000_80FF, 32'h0, 1'b0, LAT);
    access("lb0",   1'b0, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, LAT);
    access("lbu0",  1'b0, 3'b100, 32'h0, 32'h0, 32'h0000_00FF, 1'b0, lat_for(1));
    access("lh0",   1'b0, 3'b001, 32'h0, 32'h0, 32'hFFFF_80FF, 1'b0, lat_for(1));
    access("lhu0",  1'b0, 3'b101, 32'h0, 32'h0, 32'h0000_80FF, 1'b0, lat_for(1));

    access("sw4",   1'b1, 3'b010, 32'h4, 32'h1122_3344, 32'h0, 1'b0, LAT);
    access("sb5",   1'b1, 3'b000, 32'h5, 32'h0000_00AB, 32'h0, 1'b0, LAT);
    access("lw4",   1'b0, 3'b010, 32'h4, 32'h0, 32'h1122_AB44, 1'b0, LAT);
    access("lw44",  1'b0, 3'b010, 32'h44, 32'h0, 32'h1122_AB44, 1'b0, lat_for(1));
    access("lbu7",  1'b0, 3'b100, 32'h7, 32'h0, 32'h0000_0011, 1'b0, lat_for(1));

    access("lw2",   1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 1'b1, LAT);
    access("sh3",   1'b1, 3'b001, 32'h3, 32'h0000_5555, 32'h0, 1'b1, LAT);
    access("sbu0",  1'b1, 3'b100, 32'h0, 32'h0000_0012, 32'h0, 1'b1, LAT);
    access("ld011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, LAT);
    access("lw0a",  1'b0, 3'b010, 32'h0, 32'h0, 32'h0000_80FF, 1'b0, LAT);
    access("lw0b",  1'b0, 3'b010, 32'h0, 32'h0, 32'h0000_80FF, 1'b0, lat_for(1));

    // Reset while a store is in BUSY: no response and no write.
    @(negedge clk);
    req_valid  = 1'b1;
    req_fcn    = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'hC;
    req_data   = 32'h5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_val("rstmid.busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("rstmid.busy_clr", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
      if (i == 1) begin
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_val("rstmid.ready", 32'(req_ready), 32'd1);
      end
    end
    check_val("rstmid.no_resp", 32'(seen), 32'd0);
    access("lwC",   1'b0, 3'b010, 32'hC, 32'h0, 32'h0, 1'b0, LAT);
    access("lw8r",  1'b0, 3'b010, 32'h8, 32'h0, 32'h0, 1'b0, LAT);

    access("lw10a", 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0, LAT);
    access("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0, lat_for(1));
    access("sb10",  1'b1, 3'b000, 32'h10, 32'h0000_007F, 32'h0, 1'b0, LAT);
    access("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'h0000_007F, 1'b0, lat_for(1));
    access("lw14",  1'b0, 3'b010, 32'h14, 32'h0, 32'h0, 1'b0, LAT);

    check_val("sb.empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
